// File: rtl/regwrite_checker.sv
// Register-file write monitor: compares snooped writes against a programmable
// table of expected (register, value) pairs and reports pass/fail with a timeout.
module regwrite_checker #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned NUM_CHECKS = 4,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   parameter int unsigned CNT_W      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_valid,
   input  logic [REG_AW-1:0] cfg_reg,
   input  logic [XLEN-1:0]   cfg_val,
   input  logic              ordered,
   input  logic              start,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic [IDX_W-1:0]  fail_idx,
   output logic [XLEN-1:0]   fail_data,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CHECKS-1:0]   valid_q, hit_q, hit_d, new_hit, pending;
   logic [REG_AW-1:0]       reg_q [NUM_CHECKS];
   logic [XLEN-1:0]         val_q [NUM_CHECKS];
   logic                    ordered_q, ordered_d;
   logic [CNT_W-1:0]        count_d;
   logic [1:0]              code_d;
   logic [IDX_W-1:0]        idx_d, ptr, first_pending;
   logic [XLEN-1:0]         data_d, ptr_val;
   logic [REG_AW-1:0]       ptr_reg;
   logic                    ptr_found, snoop, mismatch, complete, cfg_ok;

   assign cfg_ok = cfg_we && (state_q != RUN) && (32'(cfg_idx) < NUM_CHECKS);
   assign snoop  = wb_we && (wb_rd != '0) && (state_q == RUN);

   // Expected-value table; retained across runs, only cleared by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_CHECKS; i++) begin
            reg_q[i] <= '0;
            val_q[i] <= '0;
         end
      end else if (cfg_ok) begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               valid_q[i] <= cfg_valid;
               reg_q[i]   <= cfg_reg;
               val_q[i]   <= cfg_val;
            end
         end
      end
   end

   // ptr is the lowest valid entry not yet hit; ordered mode only ever hits ptr
   always_comb begin
      ptr       = '0;
      ptr_found = 1'b0;
      ptr_reg   = '0;
      ptr_val   = '0;
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
         if (valid_q[i] && !hit_q[i]) begin
            ptr       = IDX_W'(i);
            ptr_found = 1'b1;
            ptr_reg   = reg_q[i];
            ptr_val   = val_q[i];
         end
      end
   end

   always_comb begin
      new_hit  = '0;
      mismatch = 1'b0;
      if (snoop) begin
         if (ordered_q) begin
            if (ptr_found && (wb_rd == ptr_reg)) begin
               if (wb_data == ptr_val) begin
                  for (int i = 0; i < NUM_CHECKS; i++)
                     if (ptr == IDX_W'(i)) new_hit[i] = 1'b1;
               end else begin
                  mismatch = 1'b1;
               end
            end
         end else begin
            for (int i = 0; i < NUM_CHECKS; i++)
               if (valid_q[i] && !hit_q[i] && (wb_rd == reg_q[i]) && (wb_data == val_q[i]))
                  new_hit[i] = 1'b1;
         end
      end
      pending       = valid_q & ~(hit_q | new_hit);
      complete      = (pending == '0);
      first_pending = '0;
      for (int i = NUM_CHECKS - 1; i >= 0; i--)
         if (pending[i]) first_pending = IDX_W'(i);
   end

   // Next state and next result values
   always_comb begin
      state_d   = state_q;
      hit_d     = hit_q;
      ordered_d = ordered_q;
      count_d   = cycle_count;
      code_d    = fail_code;
      idx_d     = fail_idx;
      data_d    = fail_data;
      case (state_q)
         RUN: begin
            count_d = cycle_count + CNT_W'(1);
            hit_d   = hit_q | new_hit;
            if (mismatch) begin
               state_d = FAIL;
               code_d  = 2'd1;
               idx_d   = ptr;
               data_d  = wb_data;
            end else if (complete) begin
               state_d = PASS;
            end else if (cycle_count == CNT_W'(TIMEOUT - 1)) begin
               state_d = FAIL;
               code_d  = 2'd2;
               idx_d   = first_pending;
               data_d  = '0;
            end
         end
         default: begin
            if (start) begin
               state_d   = RUN;
               ordered_d = ordered;
               hit_d     = '0;
               count_d   = '0;
               code_d    = '0;
               idx_d     = '0;
               data_d    = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         hit_q       <= '0;
         ordered_q   <= 1'b0;
         cycle_count <= '0;
         fail_code   <= '0;
         fail_idx    <= '0;
         fail_data   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         ordered_q   <= ordered_d;
         cycle_count <= count_d;
         fail_code   <= code_d;
         fail_idx    <= idx_d;
         fail_data   <= data_d;
         busy        <= (state_d == RUN);
         done        <= (state_d == PASS) || (state_d == FAIL);
         pass        <= (state_d == PASS);
      end
   end

endmodule

// File: tb/tb_regwrite_checker.sv
// Directed bench for regwrite_checker: table of run scenarios plus hand-written
// sequences for config-during-run, start/config collision and mid-run reset.
module tb_regwrite_checker;

   logic        clk, reset, cfg_we, cfg_valid, ordered, start, wb_we;
   logic [1:0]  cfg_idx;
   logic [4:0]  cfg_reg, wb_rd;
   logic [31:0] cfg_val, wb_data;
   logic        busy, done, pass;
   logic [1:0]  fail_code, fail_idx;
   logic [31:0] fail_data;
   logic [4:0]  cycle_count;

   int tests = 0;
   int fails = 0;

   regwrite_checker #(.XLEN(32), .REG_AW(5), .NUM_CHECKS(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
      .cfg_reg(cfg_reg), .cfg_val(cfg_val), .ordered(ordered), .start(start),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .done(done),
      .pass(pass), .fail_code(fail_code), .fail_idx(fail_idx), .fail_data(fail_data),
      .cycle_count(cycle_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string             name;
      logic              ord;
      int                nent;
      logic [1:0][4:0]   er;
      logic [1:0][31:0]  ev;
      int                gap;
      int                nw;
      logic [3:0][4:0]   wr;
      logic [3:0][31:0]  wd;
      logic              ep;
      logic [1:0]        ec;
      logic [1:0]        ei;
      logic [31:0]       ed;
      int                cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int idx, input logic v, input logic [4:0] r, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_valid = v; cfg_reg = r; cfg_val = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d);
      wb_we = 1'b1; wb_rd = r; wb_data = d;
      tick();
      wb_we = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 40 && !done; i++) tick();
      check({name, ".done"}, 32'(done), 32'd1);
   endtask

   task automatic check_result(input string name, input logic ep, input logic [1:0] ec,
                               input logic [1:0] ei, input logic [31:0] ed, input int cnt);
      check({name, ".pass"}, 32'(pass), 32'(ep));
      check({name, ".busy"}, 32'(busy), 32'd0);
      check({name, ".fail_code"}, 32'(fail_code), 32'(ec));
      check({name, ".fail_idx"}, 32'(fail_idx), 32'(ei));
      check({name, ".fail_data"}, fail_data, ed);
      check({name, ".cycle_count"}, 32'(cycle_count), 32'(cnt));
   endtask

   initial begin
      vecs[0] = '{name:"single", ord:1'b1, nent:1, er:{5'd0, 5'd5}, ev:{32'h0, 32'h2}, gap:3, nw:1,
                  wr:{5'd0, 5'd0, 5'd0, 5'd5}, wd:{32'h0, 32'h0, 32'h0, 32'h2},
                  ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:4};
      vecs[1] = '{name:"ord_mismatch", ord:1'b1, nent:2, er:{5'd2, 5'd1}, ev:{32'h20, 32'h10}, gap:0, nw:2,
                  wr:{5'd0, 5'd0, 5'd2, 5'd1}, wd:{32'h0, 32'h0, 32'h21, 32'h10},
                  ep:1'b0, ec:2'd1, ei:2'd1, ed:32'h21, cnt:2};
      vecs[2] = '{name:"unord_overwrite", ord:1'b0, nent:2, er:{5'd2, 5'd1}, ev:{32'h20, 32'h10}, gap:0, nw:3,
                  wr:{5'd0, 5'd1, 5'd2, 5'd2}, wd:{32'h0, 32'h10, 32'h20, 32'h7},
                  ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:3};
      vecs[3] = '{name:"ord_skip_other", ord:1'b1, nent:2, er:{5'd2, 5'd1}, ev:{32'h20, 32'h10}, gap:0, nw:4,
                  wr:{5'd2, 5'd1, 5'd2, 5'd2}, wd:{32'h20, 32'h10, 32'h20, 32'h7},
                  ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:4};
      vecs[4] = '{name:"timeout", ord:1'b1, nent:1, er:{5'd0, 5'd3}, ev:{32'h0, 32'h1}, gap:0, nw:0,
                  wr:'0, wd:'0, ep:1'b0, ec:2'd2, ei:2'd0, ed:32'h0, cnt:16};
      vecs[5] = '{name:"complete_at_timeout", ord:1'b1, nent:1, er:{5'd0, 5'd3}, ev:{32'h0, 32'h1}, gap:15, nw:1,
                  wr:{5'd0, 5'd0, 5'd0, 5'd3}, wd:{32'h0, 32'h0, 32'h0, 32'h1},
                  ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:16};
      vecs[6] = '{name:"empty_table", ord:1'b0, nent:0, er:'0, ev:'0, gap:0, nw:0,
                  wr:'0, wd:'0, ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:1};
      vecs[7] = '{name:"x0_ignored", ord:1'b1, nent:1, er:{5'd0, 5'd0}, ev:{32'h0, 32'h5}, gap:0, nw:1,
                  wr:{5'd0, 5'd0, 5'd0, 5'd0}, wd:{32'h0, 32'h0, 32'h0, 32'h5},
                  ep:1'b0, ec:2'd2, ei:2'd0, ed:32'h0, cnt:16};
      vecs[8] = '{name:"multi_hit", ord:1'b0, nent:2, er:{5'd6, 5'd6}, ev:{32'h33, 32'h33}, gap:0, nw:1,
                  wr:{5'd0, 5'd0, 5'd0, 5'd6}, wd:{32'h0, 32'h0, 32'h0, 32'h33},
                  ep:1'b1, ec:2'd0, ei:2'd0, ed:32'h0, cnt:1};
      vecs[9] = '{name:"unord_timeout_partial", ord:1'b0, nent:2, er:{5'd2, 5'd1}, ev:{32'h20, 32'h10}, gap:0, nw:1,
                  wr:{5'd0, 5'd0, 5'd0, 5'd1}, wd:{32'h0, 32'h0, 32'h0, 32'h10},
                  ep:1'b0, ec:2'd2, ei:2'd1, ed:32'h0, cnt:16};

      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_valid = 1'b0; cfg_reg = '0; cfg_val = '0;
      ordered = 1'b0; start = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      #2;
      check("reset.done", 32'(done), 32'd0);
      check_result("reset", 1'b0, 2'd0, 2'd0, 32'h0, 0);
      #10 reset = 1'b0;
      tick();

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++)
            cfg(i, i < vecs[k].nent, (i < 2) ? vecs[k].er[i[0]] : 5'd0, (i < 2) ? vecs[k].ev[i[0]] : 32'h0);
         ordered = vecs[k].ord;
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (vecs[k].gap) tick();
         for (int w = 0; w < vecs[k].nw; w++) wr(vecs[k].wr[w], vecs[k].wd[w]);
         wait_done(vecs[k].name);
         tick(); tick();
         check_result(vecs[k].name, vecs[k].ep, vecs[k].ec, vecs[k].ei, vecs[k].ed, vecs[k].cnt);
      end

      // Config writes during RUN must be dropped
      cfg(0, 1'b1, 5'd7, 32'h1);
      cfg(1, 1'b0, 5'd0, 32'h0);
      cfg(2, 1'b0, 5'd0, 32'h0);
      cfg(3, 1'b0, 5'd0, 32'h0);
      ordered = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      cfg(1, 1'b1, 5'd8, 32'h2);
      cfg(0, 1'b1, 5'd7, 32'hff);
      wr(5'd7, 32'h1);
      wait_done("cfg_in_run");
      check_result("cfg_in_run", 1'b1, 2'd0, 2'd0, 32'h0, 3);

      // Config write in the start cycle lands before the run
      cfg_we = 1'b1; cfg_idx = 2'd1; cfg_valid = 1'b1; cfg_reg = 5'd8; cfg_val = 32'h2;
      start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      wr(5'd7, 32'h1);
      wr(5'd8, 32'h2);
      wait_done("start_cfg");
      check_result("start_cfg", 1'b1, 2'd0, 2'd0, 32'h0, 2);

      // Reset mid-run aborts and invalidates the table
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("midrun.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("midrun.done", 32'(done), 32'd0);
      check_result("midrun", 1'b0, 2'd0, 2'd0, 32'h0, 0);
      #3 reset = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("post_reset.done", 32'(done), 32'd1);
      check_result("post_reset", 1'b1, 2'd0, 2'd0, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
